ahb_burst_splitter: RTL and testbench

- Upstream command stage for the AHB manager.
- Accepts one long linear transfer request (start address, beat count up to 65535, size, direction).
- Splits it into a sequence of AHB burst commands: INCR16, INCR8, INCR4 or SINGLE.
- No command crosses a 1KB address boundary.
- Commands are handed to the manager one at a time over a valid/ready interface.
- Burst and size encodings are the t_hburst and t_hsize types from ahb_manager_pack.

---
 rtl/ahb_burst_splitter.sv | 176 +++++++++++++++++
 tb/tb_ahb_burst_splitter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_splitter.sv
`default_nettype none
// ============================================================================
// ahb_burst_splitter : splits a long linear transfer into 1KB-safe AHB
//                      INCR16/INCR8/INCR4/SINGLE commands, one at a time.
// Revision: 1.0
// ============================================================================

package ahb_manager_pack;
    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } t_hburst;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } t_hsize;
endpackage

module ahb_burst_splitter
    import ahb_manager_pack::*;
#(
    parameter int MAX_SIZE   = 2,
    parameter int BOUND_LOG2 = 10
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [15:0] i_req_len,
    input  logic [2:0]  i_req_size,
    input  logic        i_req_write,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [31:0] o_cmd_addr,
    output logic [2:0]  o_cmd_hburst,
    output logic [4:0]  o_cmd_beats,
    output logic [2:0]  o_cmd_size,
    output logic        o_cmd_write,
    output logic        o_cmd_last,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } t_state;

    t_state      state_q;
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    t_hsize      size_q;
    logic        write_q;

    logic [4:0]  beats_d;
    t_hburst     hburst_d;
    logic        last_d;
    logic [31:0] req_addr_aligned;

    // 33-bit end address so a carry past 0xFFFFFFFF shows up as a block change.
    function automatic logic crosses(input logic [31:0] a, input logic [4:0] n,
                                     input t_hsize sz);
        logic [32:0] end_byte;
        end_byte = {1'b0, a} + (33'(n) << sz) - 33'd1;
        return (end_byte >> BOUND_LOG2) != ({1'b0, a} >> BOUND_LOG2);
    endfunction

    always_comb begin
        beats_d  = 5'd1;
        hburst_d = HBURST_SINGLE;
        if (rem_q >= 16'd16 && !crosses(addr_q, 5'd16, size_q)) begin
            beats_d  = 5'd16;
            hburst_d = HBURST_INCR16;
        end else if (rem_q >= 16'd8 && !crosses(addr_q, 5'd8, size_q)) begin
            beats_d  = 5'd8;
            hburst_d = HBURST_INCR8;
        end else if (rem_q >= 16'd4 && !crosses(addr_q, 5'd4, size_q)) begin
            beats_d  = 5'd4;
            hburst_d = HBURST_INCR4;
        end
        last_d = (rem_q == 16'(beats_d));
    end

    assign req_addr_aligned = i_req_addr & ~((32'd1 << i_req_size) - 32'd1);

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            size_q       <= HSIZE_8;
            write_q      <= 1'b0;
            o_req_ready  <= 1'b1;
            o_cmd_valid  <= 1'b0;
            o_cmd_addr   <= '0;
            o_cmd_hburst <= '0;
            o_cmd_beats  <= '0;
            o_cmd_size   <= '0;
            o_cmd_write  <= 1'b0;
            o_cmd_last   <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        addr_q      <= req_addr_aligned;
                        rem_q       <= i_req_len;
                        size_q      <= t_hsize'(i_req_size);
                        write_q     <= i_req_write;
                        o_req_ready <= 1'b0;
                        if (i_req_size > 3'(MAX_SIZE)) begin
                            state_q <= ST_DONE;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                        end else if (i_req_len == 16'd0) begin
                            state_q <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    o_cmd_addr   <= addr_q;
                    o_cmd_hburst <= hburst_d;
                    o_cmd_beats  <= beats_d;
                    o_cmd_size   <= size_q;
                    o_cmd_write  <= write_q;
                    o_cmd_last   <= last_d;
                    o_cmd_valid  <= 1'b1;
                    state_q      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        addr_q      <= addr_q + (32'(o_cmd_beats) << size_q);
                        rem_q       <= rem_q - 16'(o_cmd_beats);
                        if (o_cmd_last) begin
                            state_q <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    o_req_ready <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_burst_splitter.sv
`default_nettype none
// ============================================================================
// tb_ahb_burst_splitter : scoreboard bench, directed cases plus random traffic.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_ahb_burst_splitter;

    logic        clk = 1'b0;
    logic        i_hreset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic [15:0] i_req_len = '0;
    logic [2:0]  i_req_size = '0;
    logic        i_req_write = 1'b0;
    logic        o_cmd_valid;
    logic        i_cmd_ready = 1'b0;
    logic [31:0] o_cmd_addr;
    logic [2:0]  o_cmd_hburst;
    logic [4:0]  o_cmd_beats;
    logic [2:0]  o_cmd_size;
    logic        o_cmd_write;
    logic        o_cmd_last;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    ahb_burst_splitter #(.MAX_SIZE(2), .BOUND_LOG2(10)) dut (
        .i_hclk      (clk),
        .i_hreset    (i_hreset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .i_req_size  (i_req_size),
        .i_req_write (i_req_write),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_hburst(o_cmd_hburst),
        .o_cmd_beats (o_cmd_beats),
        .o_cmd_size  (o_cmd_size),
        .o_cmd_write (o_cmd_write),
        .o_cmd_last  (o_cmd_last),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  hburst;
        logic [4:0]  beats;
        logic [2:0]  size;
        logic        write;
        logic        last;
    } cmd_t;

    cmd_t exp_q[$];
    bit   err_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   hs_cyc = 0;
    int   done_cnt = 0;
    int   mode = 0;
    int   vcnt = 0;
    bit   busy = 1'b0;
    bit   first_pending = 1'b0;
    bit   req_had_cmd = 1'b0;
    bit   ready_viol = 1'b0;
    bit   prev_valid = 1'b0;
    bit   prev_hs = 1'b0;
    cmd_t cur;
    cmd_t held;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: greedy largest-first split; a burst fits when its bytes stay
    // inside the current 1KB block (2^32 is a block multiple, so wrap is covered).
    task automatic model_push(input logic [31:0] addr, input int len, input int size,
                              input bit wr, output bit had_cmd);
        longint a;
        int     rem;
        int     n;
        cmd_t   c;
        had_cmd = 1'b0;
        if (size > 2) begin
            err_q.push_back(1'b1);
            return;
        end
        a   = longint'(addr);
        a   = a - (a % (longint'(1) << size));
        rem = len;
        while (rem > 0) begin
            n = 1;
            for (int k = 0; k < 3; k++) begin
                int cand;
                cand = 16 >> k;
                if (n == 1 && rem >= cand && (a % 1024) + (longint'(cand) << size) <= 1024)
                    n = cand;
            end
            c.addr   = a[31:0];
            c.beats  = 5'(n);
            c.hburst = (n == 16) ? 3'd7 : (n == 8) ? 3'd5 : (n == 4) ? 3'd3 : 3'd0;
            c.size   = 3'(size);
            c.write  = wr;
            c.last   = (rem == n);
            exp_q.push_back(c);
            had_cmd = 1'b1;
            a   = (a + (longint'(n) << size)) % 64'sh1_0000_0000;
            rem = rem - n;
        end
        err_q.push_back(1'b0);
    endtask

    // Presents a request and records the model's expectation on the accept cycle.
    task automatic issue_req(input logic [31:0] addr, input int len, input int size, input bit wr);
        int guard;
        bit had;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_len   = 16'(len);
        i_req_size  = 3'(size);
        i_req_write = wr;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!o_req_ready && guard < 200);
        if (!o_req_ready) begin
            fail_now("req_ready_timeout");
        end else begin
            model_push(addr, len, size, wr, had);
            req_had_cmd   = had;
            acc_cyc       = cyc;
            first_pending = had;
            ready_viol    = 1'b0;
            busy          = 1'b1;
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] addr, input int len, input int size, input bit wr);
        int guard;
        int d0;
        d0 = done_cnt;
        issue_req(addr, len, size, wr);
        guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_cnt == d0) fail_now("done_timeout");
    endtask

    // Command-ready driver: 0 = always ready, 1 = random, 2 = hold off 5 cycles per command.
    always @(posedge clk) begin
        #1;
        if (o_cmd_valid) vcnt++;
        else vcnt = 0;
        case (mode)
            0:       i_cmd_ready = 1'b1;
            1:       i_cmd_ready = ($urandom_range(0, 2) != 0);
            default: i_cmd_ready = (vcnt > 5);
        endcase
    end

    // Monitor: compares every handshake and every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!i_hreset) begin
            if (o_cmd_valid) begin
                cur = {o_cmd_addr, o_cmd_hburst, o_cmd_beats, o_cmd_size, o_cmd_write, o_cmd_last};
                if (prev_valid && !prev_hs) check("cmd_stable", 64'(cur), 64'(held));
                if (first_pending) begin
                    check("first_cmd_latency", 64'(cyc - acc_cyc), 64'd2);
                    first_pending = 1'b0;
                end
                if (i_cmd_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_cmd");
                    else check("cmd", 64'(cur), 64'(exp_q.pop_front()));
                    hs_cyc = cyc;
                end
                held = cur;
            end
            if (o_done) begin
                check("cmds_left_at_done", 64'(exp_q.size()), 64'd0);
                if (err_q.size() == 0) fail_now("unexpected_done");
                else check("err", 64'(o_err), 64'(err_q.pop_front()));
                check("done_latency", 64'(cyc), 64'(req_had_cmd ? hs_cyc + 1 : acc_cyc + 1));
                check("req_ready_low_in_flight", 64'(ready_viol), 64'd0);
                busy = 1'b0;
                done_cnt++;
            end else if (o_err) begin
                fail_now("err_without_done");
            end
            if (busy && cyc != acc_cyc && o_req_ready) ready_viol = 1'b1;
            prev_valid = o_cmd_valid;
            prev_hs    = o_cmd_valid && i_cmd_ready;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          len;
        int          sz;
        int          r;
        int          guard;

        i_hreset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        check("rst_cmd_valid", 64'(o_cmd_valid), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_cmd_fields", 64'({o_cmd_addr, o_cmd_hburst, o_cmd_beats, o_cmd_last}), 64'd0);
        @(posedge clk);
        #1;
        i_hreset = 1'b0;

        mode = 0;
        do_req(32'h0000_0000, 45, 2, 1'b1);
        do_req(32'h0000_03F0, 20, 2, 1'b0);
        mode = 2;
        do_req(32'h0000_0000, 45, 2, 1'b1);
        mode = 0;
        do_req(32'h0000_0200, 0, 2, 1'b0);
        do_req(32'h0000_0200, 8, 3, 1'b1);
        do_req(32'hFFFF_FFF8, 4, 2, 1'b1);

        // Reset while a command is being held off.
        mode = 2;
        issue_req(32'h0000_0000, 45, 2, 1'b1);
        guard = 0;
        while (!o_cmd_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!o_cmd_valid) fail_now("cmd_valid_timeout");
        @(posedge clk);
        #1;
        i_hreset = 1'b1;
        exp_q.delete();
        err_q.delete();
        busy = 1'b0;
        first_pending = 1'b0;
        @(posedge clk);
        #1;
        i_hreset = 1'b0;
        @(negedge clk);
        check("midrst_cmd_valid", 64'(o_cmd_valid), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_req_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk);
        #1;
        mode = 0;
        do_req(32'h0000_0100, 4, 2, 1'b1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       a = $urandom;
                1:       a = ($urandom & 32'hFFFF_FC00) + 32'h400 - 32'($urandom_range(0, 64));
                2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 200));
                default: a = 32'($urandom_range(0, 4095));
            endcase
            len  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(100, 400))
                                                 : int'($urandom_range(0, 70));
            r    = $urandom_range(0, 9);
            sz   = (r == 0) ? 3 : (r % 3);
            mode = i % 3;
            do_req(a, len, sz, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
